// File: rtl/piece_pkg.sv
// Shared types and constants for the piece queue: piece encoding and queue FSM states.
package piece_pkg;
  typedef logic [2:0] piece_t;

  localparam piece_t PIECE_EMPTY = 3'd7;
  localparam int     NUM_PIECES  = 7;

  typedef enum logic {
    ST_PRIME,
    ST_PLAY
  } queue_state_e;

  function automatic logic is_piece(piece_t p);
    return p != PIECE_EMPTY;
  endfunction
endpackage

// File: rtl/piece_queue_if.sv
// Generator/game-logic facing signals of the piece queue, grouped with driver and queue views.
interface piece_queue_if #(
  parameter int DEPTH = 4
);
  import piece_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  piece_t           in_piece;
  logic             in_ready;
  logic             next_req;
  logic             hold_req;
  piece_t           cur_piece;
  logic             cur_valid;
  piece_t           hold_piece;
  logic             hold_used;
  piece_t           preview0;
  piece_t           preview1;
  piece_t           preview2;
  logic [CNT_W-1:0] count;
  logic             req_err;

  modport master (
    output in_valid, in_piece, next_req, hold_req,
    input  in_ready, cur_piece, cur_valid, hold_piece, hold_used,
           preview0, preview1, preview2, count, req_err
  );

  modport slave (
    input  in_valid, in_piece, next_req, hold_req,
    output in_ready, cur_piece, cur_valid, hold_piece, hold_used,
           preview0, preview1, preview2, count, req_err
  );
endinterface

// File: rtl/piece_fifo.sv
// Circular piece buffer with head/tail pointers, occupancy count and a three-entry peek window.
module piece_fifo
  import piece_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  piece_t           push_data_i,
  input  logic             pop_i,
  output piece_t           peek0_o,
  output piece_t           peek1_o,
  output piece_t           peek2_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_add(logic [PTR_W-1:0] p, int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  piece_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;
  piece_t           peek [3];

  // Guard against over/underflow even if the caller misbehaves.
  assign push_ok = push_i && (count_q < FULL);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = ptr_add(tail_q, 1);
    if (pop_ok)  head_d = ptr_add(head_q, 1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      peek[k] = PIECE_EMPTY;
      if (int'(count_q) > k) peek[k] = mem_q[ptr_add(head_q, k)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PIECE_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok) mem_q[tail_q] <= push_data_i;
    end
  end

  assign peek0_o = peek[0];
  assign peek1_o = peek[1];
  assign peek2_o = peek[2];
  assign count_o = count_q;
endmodule

// File: rtl/piece_queue.sv
// Piece queue: buffers generator output, primes the first piece, serves next/hold requests.
// state | meaning
// PRIME | filling the buffer; requests ignored until it is full, then first piece auto-popped
// PLAY  | current piece valid; next_req pops, hold_req parks or swaps the current piece
module piece_queue
  import piece_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  piece_queue_if.slave  bus
);
  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  queue_state_e     state_q, state_d;
  piece_t           cur_q, cur_d;
  logic             cur_valid_q, cur_valid_d;
  piece_t           hold_q, hold_d;
  logic             hold_used_q, hold_used_d;
  logic             err_q, err_d;
  logic             push, pop, in_ready;
  logic [CNT_W-1:0] fifo_count;
  piece_t           peek0, peek1, peek2;

  assign in_ready = fifo_count < FULL;
  assign push     = bus.in_valid && in_ready && is_piece(bus.in_piece);

  piece_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus.in_piece),
    .pop_i       (pop),
    .peek0_o     (peek0),
    .peek1_o     (peek1),
    .peek2_o     (peek2),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cur_valid_d = cur_valid_q;
    hold_d      = hold_q;
    hold_used_d = hold_used_q;
    err_d       = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      ST_PRIME: begin
        if (fifo_count == FULL) begin
          pop         = 1'b1;
          cur_d       = peek0;
          cur_valid_d = 1'b1;
          state_d     = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.next_req) begin
          if (fifo_count != '0) begin
            pop         = 1'b1;
            cur_d       = peek0;
            hold_used_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.hold_req && !hold_used_q) begin
          // An empty hold slot consumes a queued piece; an occupied one only swaps.
          if (hold_q == PIECE_EMPTY) begin
            if (fifo_count != '0) begin
              pop         = 1'b1;
              hold_d      = cur_q;
              cur_d       = peek0;
              hold_used_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cur_d       = hold_q;
            hold_d      = cur_q;
            hold_used_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PRIME;
      cur_q       <= PIECE_EMPTY;
      cur_valid_q <= 1'b0;
      hold_q      <= PIECE_EMPTY;
      hold_used_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cur_valid_q <= cur_valid_d;
      hold_q      <= hold_d;
      hold_used_q <= hold_used_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.cur_piece  = cur_q;
  assign bus.cur_valid  = cur_valid_q;
  assign bus.hold_piece = hold_q;
  assign bus.hold_used  = hold_used_q;
  assign bus.preview0   = peek0;
  assign bus.preview1   = peek1;
  assign bus.preview2   = peek2;
  assign bus.count      = fifo_count;
  assign bus.req_err    = err_q;
endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_piece_queue;
  import piece_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  piece_queue_if #(.DEPTH(DEPTH)) dif ();

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  int vectors;
  int miscompares;

  // reference model state
  piece_t mq[$];
  piece_t m_cur, m_hold;
  bit     m_cur_valid, m_hold_used, m_play, m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic piece_t m_prev(int k);
    if (mq.size() > k) return mq[k];
    return PIECE_EMPTY;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur       = PIECE_EMPTY;
    m_hold      = PIECE_EMPTY;
    m_cur_valid = 1'b0;
    m_hold_used = 1'b0;
    m_play      = 1'b0;
    m_err       = 1'b0;
  endtask

  task automatic model_edge();
    int     n;
    bit     do_push;
    piece_t t;
    if (reset) return;
    n       = mq.size();
    do_push = dif.in_valid && (n < DEPTH) && (dif.in_piece != PIECE_EMPTY);
    m_err   = 1'b0;
    if (!m_play) begin
      if (n == DEPTH) begin
        m_cur       = mq.pop_front();
        m_cur_valid = 1'b1;
        m_play      = 1'b1;
      end
    end else if (dif.next_req) begin
      if (n > 0) begin
        m_cur       = mq.pop_front();
        m_hold_used = 1'b0;
      end else m_err = 1'b1;
    end else if (dif.hold_req && !m_hold_used) begin
      if (m_hold == PIECE_EMPTY) begin
        if (n > 0) begin
          m_hold      = m_cur;
          m_cur       = mq.pop_front();
          m_hold_used = 1'b1;
        end else m_err = 1'b1;
      end else begin
        t           = m_cur;
        m_cur       = m_hold;
        m_hold      = t;
        m_hold_used = 1'b1;
      end
    end
    if (do_push) mq.push_back(dif.in_piece);
  endtask

  task automatic drive(bit v, piece_t p, bit n, bit h);
    dif.in_valid = v;
    dif.in_piece = p;
    dif.next_req = n;
    dif.hold_req = h;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // whole-output comparison against the model on every falling edge
  always @(negedge clk) begin
    logic [22:0] act, exp;
    act = {dif.in_ready, dif.cur_piece, dif.cur_valid, dif.hold_piece, dif.hold_used,
           dif.preview0, dif.preview1, dif.preview2, 4'(dif.count), dif.req_err};
    exp = {(mq.size() < DEPTH), m_cur, m_cur_valid, m_hold, m_hold_used,
           m_prev(0), m_prev(1), m_prev(2), 4'(mq.size()), m_err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model_cmp: got %h, expected %h at %0t", act, exp, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(0, 3'd0, 0, 0);
    model_reset();
    cycle();
    cycle();
    chk("rst_cur", dif.cur_piece, 7);
    chk("rst_cur_valid", dif.cur_valid, 0);
    chk("rst_hold", dif.hold_piece, 7);
    chk("rst_count", dif.count, 0);
    chk("rst_in_ready", dif.in_ready, 1);
    reset = 1'b0;

    // fill 1,2,3,4 with requests offered during PRIME (must be ignored)
    drive(1, 3'd1, 1, 0); cycle();
    drive(1, 3'd2, 0, 1); cycle();
    drive(1, 3'd3, 1, 1); cycle();
    drive(1, 3'd4, 0, 0); cycle();
    chk("full_count", dif.count, 4);
    chk("full_in_ready", dif.in_ready, 0);
    chk("prime_cur_valid", dif.cur_valid, 0);
    drive(0, 3'd0, 0, 0); cycle();
    chk("prime_cur", dif.cur_piece, 1);
    chk("prime_cur_valid1", dif.cur_valid, 1);
    chk("prime_p0", dif.preview0, 2);
    chk("prime_p1", dif.preview1, 3);
    chk("prime_p2", dif.preview2, 4);
    chk("prime_count", dif.count, 3);

    drive(0, 3'd0, 1, 0); cycle();
    chk("next_cur", dif.cur_piece, 2);
    chk("next_p0", dif.preview0, 3);
    chk("next_p1", dif.preview1, 4);
    chk("next_p2", dif.preview2, 7);
    chk("next_count", dif.count, 2);
    chk("next_hold_used", dif.hold_used, 0);

    drive(0, 3'd0, 0, 1); cycle();
    chk("hold_hold", dif.hold_piece, 2);
    chk("hold_cur", dif.cur_piece, 3);
    chk("hold_used", dif.hold_used, 1);
    chk("hold_count", dif.count, 1);
    cycle();
    chk("hold2_cur", dif.cur_piece, 3);
    chk("hold2_hold", dif.hold_piece, 2);
    chk("hold2_err", dif.req_err, 0);

    drive(1, 3'd7, 0, 0); cycle(); cycle();
    chk("empty_code_count", dif.count, 1);

    drive(0, 3'd0, 1, 0); cycle();
    chk("drain_cur", dif.cur_piece, 4);
    chk("drain_count", dif.count, 0);
    cycle();
    chk("under_err", dif.req_err, 1);
    chk("under_cur", dif.cur_piece, 4);
    drive(0, 3'd0, 0, 0); cycle();
    chk("under_err_clear", dif.req_err, 0);

    drive(0, 3'd0, 0, 1); cycle();
    chk("swap_cur", dif.cur_piece, 2);
    chk("swap_hold", dif.hold_piece, 4);
    chk("swap_count", dif.count, 0);

    drive(1, 3'd5, 0, 0); cycle();
    drive(1, 3'd6, 0, 0); cycle();
    drive(1, 3'd0, 0, 0); cycle();
    drive(1, 3'd1, 0, 0); cycle();
    chk("refill_count", dif.count, 4);
    chk("refill_cur", dif.cur_piece, 2);

    drive(1, 3'd5, 1, 0); cycle();
    chk("fullpush_cur", dif.cur_piece, 5);
    chk("fullpush_count", dif.count, 3);
    chk("fullpush_p2", dif.preview2, 1);

    drive(0, 3'd0, 1, 1); cycle();
    chk("both_cur", dif.cur_piece, 6);
    chk("both_hold", dif.hold_piece, 4);
    chk("both_hold_used", dif.hold_used, 0);

    drive(1, 3'd3, 1, 0); cycle();
    chk("pushpop_cur", dif.cur_piece, 0);
    chk("pushpop_count", dif.count, 2);
    chk("pushpop_p1", dif.preview1, 3);

    // mid-cycle asynchronous reset
    drive(0, 3'd0, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_cur", dif.cur_piece, 7);
    chk("async_cur_valid", dif.cur_valid, 0);
    chk("async_hold", dif.hold_piece, 7);
    chk("async_count", dif.count, 0);
    chk("async_p0", dif.preview0, 7);
    cycle();
    reset = 1'b0;

    drive(1, 3'd2, 1, 1); cycle();
    drive(1, 3'd3, 0, 0); cycle();
    drive(1, 3'd4, 0, 1); cycle();
    drive(1, 3'd5, 0, 0); cycle();
    drive(0, 3'd0, 0, 0); cycle();
    chk("reprime_cur", dif.cur_piece, 2);
    chk("reprime_count", dif.count, 3);
    chk("reprime_hold", dif.hold_piece, 7);

    // pseudo-random traffic, model-checked every cycle
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      cycle();
    end
    drive(0, 3'd0, 0, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
